// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains a synchronous FIFO one word at a time and transmits
//               each word as an asynchronous serial frame: start bit, data
//               bits LSB first, optional even parity bit, then one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    // A baud counter of at least one bit keeps CLKS_PER_BIT == 2 legal.
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is requested one cycle before the last
    // cycle of the stop bit.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state_q,   state_d;
    logic [BAUD_W-1:0]     baud_q,    baud_d;
    logic [BIT_W-1:0]      bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic                  parity_q,  parity_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;
    logic                  tx_done_q, tx_done_d;
    logic                  baud_end;

    // Pop only from IDLE, so the FIFO can never be read while a frame is
    // in flight; reset blocks the pop in the same cycle.
    assign fifo_rd  = (state_q == S_IDLE) & tx_en & ~fifo_empty & ~rst;
    assign baud_end = (baud_q == BAUD_LAST);

    // Next-state, counters, shift register and the registered outputs,
    // which are computed from the state being entered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_done_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (fifo_rd) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // fifo_dout is valid the cycle after the pop.
                shift_d  = fifo_dout;
                parity_d = ^fifo_dout;
                baud_d   = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                tx_done_d = (baud_q == BAUD_PRE);
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Single state register; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx. Two instances (without
//               and with parity) are fed from queue-based FIFO models; words
//               are pushed to a scoreboard when written and compared against
//               the frames decoded from the serial line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       tx_en0 = 1'b0, fifo_empty0 = 1'b1, fifo_rd0, tx0, busy0, tx_done0;
    logic [7:0] fifo_dout0 = 8'h00;
    logic       tx_en1 = 1'b0, fifo_empty1 = 1'b1, fifo_rd1, tx1, busy1, tx_done1;
    logic [7:0] fifo_dout1 = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] fq0[$], fq1[$];
    logic [7:0] exp0[$], exp1[$];
    int         rd_t0[$];
    int         last_rd[2];
    int         rd_cnt[2];
    int         done_cnt[2];
    int         frames_ok[2];

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_en(tx_en0), .fifo_empty(fifo_empty0),
        .fifo_dout(fifo_dout0), .fifo_rd(fifo_rd0), .tx(tx0), .busy(busy0),
        .tx_done(tx_done0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty1),
        .fifo_dout(fifo_dout1), .fifo_rd(fifo_rd1), .tx(tx1), .busy(busy1),
        .tx_done(tx_done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic txs(input int k);
        return (k == 0) ? tx0 : tx1;
    endfunction
    function automatic logic busys(input int k);
        return (k == 0) ? busy0 : busy1;
    endfunction
    function automatic logic dones(input int k);
        return (k == 0) ? tx_done0 : tx_done1;
    endfunction
    function automatic logic rds(input int k);
        return (k == 0) ? fifo_rd0 : fifo_rd1;
    endfunction
    function automatic int exp_size(input int k);
        return (k == 0) ? exp0.size() : exp1.size();
    endfunction

    // FIFO models: read data appears the cycle after the pop.
    always @(posedge clk) begin
        if (fifo_rd0 === 1'b1) begin
            check_eq("underflow0", 32'(fq0.size() == 0), 32'd0);
            if (fq0.size() != 0) fifo_dout0 <= fq0.pop_front();
            fifo_empty0 <= (fq0.size() == 0);
        end
        if (fifo_rd1 === 1'b1) begin
            check_eq("underflow1", 32'(fq1.size() == 0), 32'd0);
            if (fq1.size() != 0) fifo_dout1 <= fq1.pop_front();
            fifo_empty1 <= (fq1.size() == 0);
        end
    end

    // Pop and tx_done monitors.
    always @(negedge clk) begin
        if (fifo_rd0 === 1'b1) begin last_rd[0] = cyc; rd_cnt[0]++; rd_t0.push_back(cyc); end
        if (fifo_rd1 === 1'b1) begin last_rd[1] = cyc; rd_cnt[1]++; end
        if (tx_done0 === 1'b1) done_cnt[0]++;
        if (tx_done1 === 1'b1) done_cnt[1]++;
    end

    task automatic push_word(input int k, input logic [7:0] w);
        if (k == 0) begin fq0.push_back(w); exp0.push_back(w); fifo_empty0 = 1'b0; end
        else        begin fq1.push_back(w); exp1.push_back(w); fifo_empty1 = 1'b0; end
    endtask

    // Serial decoder: checks every cycle of the frame against the
    // scoreboard word, then compares the sampled byte and tx_done timing.
    task automatic decode(input int k, input int par);
        int          nb, bad, dn, dcyc;
        bit          abort;
        logic        s;
        logic [10:0] fr;
        logic [7:0]  want, got;
        nb = 10 + par;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txs(k) === 1'b0) begin
                check_eq($sformatf("rd_to_start%0d", k), 32'(cyc - last_rd[k]), 32'd2);
                want = 8'h00;
                if (exp_size(k) == 0) check_eq($sformatf("unexpected_frame%0d", k), 32'd1, 32'd0);
                else want = (k == 0) ? exp0[0] : exp1[0];
                fr = '1;
                fr[0] = 1'b0;
                fr[8:1] = want;
                if (par != 0) fr[9] = ^want;
                bad = 0; dn = 0; dcyc = -1; abort = 1'b0; got = 8'h00;
                for (int t = 0; t < nb * CPB; t++) begin
                    if (t > 0) @(negedge clk);
                    if (rst === 1'b1) begin abort = 1'b1; break; end
                    s = txs(k);
                    if (s !== fr[t / CPB] || busys(k) !== 1'b1) bad++;
                    if (dones(k) === 1'b1) begin dn++; dcyc = t; end
                    if (t % CPB == 2 && t / CPB >= 1 && t / CPB <= 8) got[t / CPB - 1] = s;
                end
                if (exp_size(k) != 0) begin
                    if (k == 0) void'(exp0.pop_front()); else void'(exp1.pop_front());
                end
                if (!abort) begin
                    check_eq($sformatf("byte%0d", k), 32'(got), 32'(want));
                    check_eq($sformatf("frame_shape%0d", k), 32'(bad), 32'd0);
                    check_eq($sformatf("done_pos%0d", k), 32'({dn[7:0], dcyc[7:0]}),
                             32'({8'd1, 8'(nb * CPB - 1)}));
                    check_eq($sformatf("done_latency%0d", k), 32'(cyc - last_rd[k]),
                             32'(nb * CPB + 1));
                    frames_ok[k]++;
                end
            end
        end
    endtask

    initial decode(0, 0);
    initial decode(1, 1);

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while (!(exp_size(k) == 0 && busys(k) === 1'b0 && rds(k) === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("idle_timeout%0d", k), 32'(n < budget), 32'd1);
    endtask

    task automatic wait_rd(input int k, input int budget);
        int n = 0;
        @(negedge clk);
        while (rds(k) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("rd_timeout%0d", k), 32'(n < budget), 32'd1);
    endtask

    initial begin
        int base;

        // Reset held 3 cycles with a word waiting and tx_en high.
        tx_en0 = 1'b1;
        push_word(0, 8'hA5);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("reset_outputs", 32'({tx0, fifo_rd0, busy0, tx_done0}), 32'(4'b1000));
        end
        @(posedge clk); #1 rst = 1'b0;

        // Single word 8'hA5.
        wait_idle(0, 200);
        check_eq("single_rd_count", 32'(rd_cnt[0]), 32'd1);

        // Burst of 8 random words, back to back.
        rd_t0.delete();
        base = rd_cnt[0];
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push_word(0, 8'($urandom_range(0, 255)));
        wait_idle(0, 1000);
        check_eq("burst_rd_count", 32'(rd_cnt[0] - base), 32'd8);
        for (int i = 1; i < rd_t0.size(); i++)
            check_eq($sformatf("burst_spacing%0d", i), 32'(rd_t0[i] - rd_t0[i-1]), 32'd42);
        repeat (50) @(negedge clk);
        check_eq("no_rd_when_empty", 32'(rd_cnt[0] - base), 32'd8);

        // Parity instance: 07 -> parity 1, 03 -> parity 0, 44-cycle frames.
        @(posedge clk); #1;
        tx_en1 = 1'b1;
        push_word(1, 8'h07);
        push_word(1, 8'h03);
        wait_idle(1, 400);

        // Reset during data bit 3; the popped word is lost.
        @(posedge clk); #1;
        push_word(0, 8'h3C);
        push_word(0, 8'hC3);
        wait_rd(0, 20);
        base = frames_ok[0];
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", 32'({tx0, busy0, tx_done0}), 32'(3'b100));
        check_eq("abort_no_frame", 32'(frames_ok[0] - base), 32'd0);
        wait_idle(0, 200);
        check_eq("after_abort_frame", 32'(frames_ok[0] - base), 32'd1);

        // tx_en dropped during START: frame completes, no pop until re-enabled.
        @(posedge clk); #1;
        push_word(0, 8'h5A);
        push_word(0, 8'h96);
        wait_rd(0, 20);
        repeat (2) @(posedge clk);
        #1 tx_en0 = 1'b0;
        base = rd_cnt[0];
        repeat (60) @(negedge clk);
        check_eq("no_rd_tx_en_low", 32'(rd_cnt[0] - base), 32'd0);
        check_eq("pending_words", 32'(exp0.size()), 32'd1);
        @(posedge clk); #1 tx_en0 = 1'b1;
        @(negedge clk);
        check_eq("pop_resumes", 32'(fifo_rd0), 32'd1);
        wait_idle(0, 200);

        // Totals: every completed frame had exactly one tx_done.
        check_eq("frames0", 32'(frames_ok[0]), 32'd12);
        check_eq("frames1", 32'(frames_ok[1]), 32'd2);
        check_eq("done_count0", 32'(done_cnt[0]), 32'(frames_ok[0]));
        check_eq("done_count1", 32'(done_cnt[1]), 32'(frames_ok[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
